// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage between instruction memory and decode.
// Owns the PC. Issues one-cycle read requests to instruction memory and keeps
// at most one request outstanding. Captures the word on ImemAck and offers it
// to decode through a valid/ready handshake. Handles redirects, including one
// that arrives while a request is still in flight, and raises a sticky error
// when an Ack does not arrive in time.
//
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   FetchEnable              level; high permits new fetch requests
//   ImemReadEnable           one-cycle read request pulse
//   ImemAddress              byte address of the request (the current PC)
//   ImemAck, ImemInstr       memory response strobe and instruction word
//   DecodeReady              decode accepts InstrValid this cycle
//   InstrValid               instruction offered to decode (combinational)
//   InstrOut, PCOut, PCPlus4 held word, its address, and that address + 4
//   Redirect, RedirectTarget taken branch/jump strobe and new PC
//   FetchError               sticky ack-timeout flag
//   FetchCount               completed decode handshakes, wraps
module instruction_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FetchEnable,
  output logic        ImemReadEnable,
  output logic [31:0] ImemAddress,
  input  logic        ImemAck,
  input  logic [31:0] ImemInstr,
  input  logic        DecodeReady,
  output logic        InstrValid,
  output logic [31:0] InstrOut,
  output logic [31:0] PCOut,
  output logic [31:0] PCPlus4,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic        FetchError,
  output logic [31:0] FetchCount
);

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN,
    S_ERROR
  } state_t;

  state_t            state, state_next;
  logic [31:0]       pc, pc_next;
  logic [CNT_W-1:0]  tmo_cnt, tmo_cnt_next;
  logic [31:0]       count_q, count_next;
  logic              err_q, err_next;
  logic              valid_q;
  logic              rd_en_q;
  logic              capture;
  logic              tmo_hit;
  logic [31:0]       target;
  logic [31:0]       instr_q, pcout_q, pcplus4_q;

  // Redirect targets are always word aligned.
  assign target  = RedirectTarget & 32'hFFFF_FFFC;
  assign tmo_hit = (tmo_cnt == CNT_W'(ACK_TIMEOUT - 1));

  // State register and datapath registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      tmo_cnt   <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      instr_q   <= '0;
      pcout_q   <= '0;
      pcplus4_q <= 32'd4;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      tmo_cnt <= tmo_cnt_next;
      count_q <= count_next;
      err_q   <= err_next;
      valid_q <= (state_next == S_HOLD);
      rd_en_q <= (state_next == S_REQ);
      if (capture) begin
        instr_q   <= ImemInstr;
        pcout_q   <= pc;
        pcplus4_q <= pc + 32'd4;
      end
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    tmo_cnt_next = tmo_cnt;
    count_next   = count_q;
    err_next     = err_q;
    capture      = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (Redirect) pc_next = target;
        if (FetchEnable) state_next = S_REQ;
      end

      S_REQ: begin
        if (Redirect) begin
          pc_next    = target;
          state_next = S_DRAIN;
        end else begin
          state_next = S_WAIT;
        end
      end

      S_WAIT: begin
        if (ImemAck) begin
          tmo_cnt_next = '0;
          if (Redirect) begin
            // Response belongs to the abandoned path; drop it.
            pc_next    = target;
            state_next = FetchEnable ? S_REQ : S_IDLE;
          end else begin
            capture    = 1'b1;
            pc_next    = pc + 32'd4;
            state_next = S_HOLD;
          end
        end else if (tmo_hit) begin
          err_next   = 1'b1;
          state_next = S_ERROR;
        end else begin
          tmo_cnt_next = tmo_cnt + CNT_W'(1);
          if (Redirect) begin
            pc_next    = target;
            state_next = S_DRAIN;
          end
        end
      end

      // Wait out the stale request so only one is ever outstanding.
      S_DRAIN: begin
        if (Redirect) pc_next = target;
        if (ImemAck) begin
          tmo_cnt_next = '0;
          state_next   = FetchEnable ? S_REQ : S_IDLE;
        end else if (tmo_hit) begin
          err_next   = 1'b1;
          state_next = S_ERROR;
        end else begin
          tmo_cnt_next = tmo_cnt + CNT_W'(1);
        end
      end

      S_HOLD: begin
        if (Redirect) begin
          pc_next    = target;
          state_next = FetchEnable ? S_REQ : S_IDLE;
        end else if (DecodeReady) begin
          count_next = count_q + 32'd1;
          state_next = FetchEnable ? S_REQ : S_IDLE;
        end
      end

      S_ERROR: begin
        state_next = S_ERROR;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign ImemReadEnable = rd_en_q;
  assign ImemAddress    = pc;
  // A redirect cancels the offer in the same cycle.
  assign InstrValid     = valid_q & ~Redirect;
  assign InstrOut       = instr_q;
  assign PCOut          = pcout_q;
  assign PCPlus4        = pcplus4_q;
  assign FetchError     = err_q;
  assign FetchCount     = count_q;

endmodule
